alu_op_sequencer: RTL and testbench

//  Initiator side of the 32-bit ALU interface (alu_ctl/alu_a/alu_b -> alu_out).

---
 rtl/alu_seq_pkg.sv | 53 +++++
 rtl/alu_op_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
//   Shared definitions for the ALU operation sequencer:
//   - SEQ_*     request op codes. Single-pass codes equal their ALU control
//               value, so the op can drive alu_ctl directly.
//   - ALU_CTL_* control values understood by the team ALU.
//   - seq_state_e  sequencer FSM states.
//   - helper predicates used to classify request op codes.
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  localparam logic [3:0] ALU_CTL_AND  = 4'd0;
  localparam logic [3:0] ALU_CTL_OR   = 4'd1;
  localparam logic [3:0] ALU_CTL_ADD  = 4'd2;
  localparam logic [3:0] ALU_CTL_SUB  = 4'd6;
  localparam logic [3:0] ALU_CTL_SLTU = 4'd7;
  localparam logic [3:0] ALU_CTL_NOR  = 4'd12;

  localparam logic [3:0] SEQ_AND  = 4'd0;
  localparam logic [3:0] SEQ_OR   = 4'd1;
  localparam logic [3:0] SEQ_ADD  = 4'd2;
  localparam logic [3:0] SEQ_SLL  = 4'd3;
  localparam logic [3:0] SEQ_MUL  = 4'd4;
  localparam logic [3:0] SEQ_BEQ  = 4'd5;
  localparam logic [3:0] SEQ_SUB  = 4'd6;
  localparam logic [3:0] SEQ_SLTU = 4'd7;
  localparam logic [3:0] SEQ_BNE  = 4'd8;
  localparam logic [3:0] SEQ_BLTU = 4'd9;
  localparam logic [3:0] SEQ_NOR  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  // Ops whose code is passed straight through to alu_ctl.
  function automatic logic is_single_pass(input logic [3:0] op);
    return (op == SEQ_ADD) || (op == SEQ_SUB) || (op == SEQ_AND) ||
           (op == SEQ_OR)  || (op == SEQ_NOR) || (op == SEQ_SLTU);
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return (op == SEQ_BEQ) || (op == SEQ_BNE) || (op == SEQ_BLTU);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return is_single_pass(op) || is_branch(op) ||
           (op == SEQ_SLL) || (op == SEQ_MUL);
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//   Initiator for the 32-bit team ALU. Takes one request at a time, drives the
//   ALU for one cycle (single-pass / branch ops) or several cycles (SLL by
//   repeated doubling, MUL-low by shift-add), then holds one registered result
//   until the consumer takes it.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_op, req_a, req_b  op code (SEQ_*), operands
//   rsp_valid/rsp_ready   response handshake; data held until taken
//   rsp_data, rsp_err     result (branch: bit0 = taken); err for illegal op
//   alu_ctl, alu_a, alu_b ALU control and operands (combinational from state)
//   alu_out               ALU result, valid in the same cycle
// ---------------------------------------------------------------------------
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MUL_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err,
  output logic [3:0]      alu_ctl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_out
);

  localparam int CNT_W = $clog2(MUL_ITERS + 1);
  localparam int SH_W  = $clog2(XLEN);

  seq_state_e        state, state_next;
  logic [3:0]        op;
  logic [XLEN-1:0]   opa;   // A; MUL multiplicand (shifted left each ITER)
  logic [XLEN-1:0]   opb;   // B; MUL multiplier (shifted right each ITER)
  logic [XLEN-1:0]   acc;   // SLL running value / MUL partial product
  logic [CNT_W-1:0]  cnt;

  logic accept;
  assign accept    = req_valid && req_ready;
  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state and ALU drive
  always_comb begin
    state_next = state;
    alu_ctl    = ALU_CTL_ADD;
    alu_a      = '0;
    alu_b      = '0;
    case (state)
      ST_IDLE: if (accept) state_next = ST_EXEC;
      ST_EXEC: begin
        if ((op == SEQ_MUL) || ((op == SEQ_SLL) && (cnt != '0)))
          state_next = ST_ITER;
        else
          state_next = ST_DONE;
        if (is_single_pass(op)) begin
          alu_ctl = op;
          alu_a   = opa;
          alu_b   = opb;
        end else if ((op == SEQ_BEQ) || (op == SEQ_BNE)) begin
          alu_ctl = ALU_CTL_SUB;
          alu_a   = opa;
          alu_b   = opb;
        end else if (op == SEQ_BLTU) begin
          alu_ctl = ALU_CTL_SLTU;
          alu_a   = opa;
          alu_b   = opb;
        end
      end
      ST_ITER: begin
        if (cnt == CNT_W'(1)) state_next = ST_DONE;
        alu_ctl = ALU_CTL_ADD;
        alu_a   = acc;
        if (op == SEQ_SLL) alu_b = acc;           // acc + acc == acc << 1
        else               alu_b = opb[0] ? opa : '0;
      end
      ST_DONE: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand, iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op       <= SEQ_ADD;
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          op  <= req_op;
          opa <= req_a;
          opb <= req_b;
          if (req_op == SEQ_SLL) begin
            acc <= req_a;
            cnt <= CNT_W'(req_b[SH_W-1:0]);
          end else begin
            acc <= '0;
            cnt <= CNT_W'(MUL_ITERS);
          end
        end
        ST_EXEC: begin
          rsp_err <= 1'b0;
          if (is_single_pass(op))  rsp_data <= alu_out;
          else if (op == SEQ_BEQ)  rsp_data <= {{(XLEN-1){1'b0}}, (alu_out == '0)};
          else if (op == SEQ_BNE)  rsp_data <= {{(XLEN-1){1'b0}}, (alu_out != '0)};
          else if (op == SEQ_BLTU) rsp_data <= {{(XLEN-1){1'b0}}, alu_out[0]};
          else if (op == SEQ_SLL) begin
            if (cnt == '0) rsp_data <= opa;     // zero shift: result is A
          end else if (op != SEQ_MUL) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        ST_ITER: begin
          acc <= alu_out;
          cnt <= cnt - CNT_W'(1);
          if (op == SEQ_MUL) begin
            opa <= opa << 1;
            opb <= opb >> 1;
          end
          if (cnt == CNT_W'(1)) rsp_data <= alu_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
//   Drives alu_op_sequencer with directed and random requests, answers the
//   ALU side with a behavioural team ALU, and compares every response against
//   a reference computed with plain arithmetic on the request operands.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, alu_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.XLEN(32), .MUL_ITERS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
  );

  // Team ALU responder
  always_comb begin
    alu_out = 32'd0;
    case (alu_ctl)
      4'd0:  alu_out = alu_a & alu_b;
      4'd1:  alu_out = alu_a | alu_b;
      4'd2:  alu_out = alu_a + alu_b;
      4'd6:  alu_out = alu_a - alu_b;
      4'd7:  alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
      4'd12: alu_out = ~(alu_a | alu_b);
      default: alu_out = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: result, error flag and accept-to-rsp_valid latency in edges.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] d, output logic e, output int lat);
    e = 1'b0; lat = 2; d = 32'd0;
    case (op)
      SEQ_ADD:  d = a + b;
      SEQ_SUB:  d = a - b;
      SEQ_AND:  d = a & b;
      SEQ_OR:   d = a | b;
      SEQ_NOR:  d = ~(a | b);
      SEQ_SLTU: d = {31'd0, a < b};
      SEQ_SLL:  begin d = a << b[4:0]; lat = 2 + int'(b[4:0]); end
      SEQ_MUL:  begin d = a * b; lat = 34; end
      SEQ_BEQ:  d = {31'd0, a == b};
      SEQ_BNE:  d = {31'd0, a != b};
      SEQ_BLTU: d = {31'd0, a < b};
      default:  e = 1'b1;
    endcase
  endtask

  // Expected alu_ctl in the EXEC cycle; -1 when not defined for the op.
  function automatic int exec_ctl(input logic [3:0] op);
    case (op)
      SEQ_ADD, SEQ_SUB, SEQ_AND, SEQ_OR, SEQ_NOR, SEQ_SLTU: return int'(op);
      SEQ_BEQ, SEQ_BNE: return 6;
      SEQ_BLTU:         return 7;
      SEQ_SLL, SEQ_MUL: return -1;
      default:          return 2;   // illegal: ALU left idle
    endcase
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit keep_req);
    logic [31:0] exp_d;
    logic        exp_e;
    int          exp_lat, lat, guard, ctl;
    string       nm;
    nm = $sformatf("op%0d", op);
    model(op, a, b, exp_d, exp_e, exp_lat);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    check({nm, "_accept_wait"}, 32'(guard < 50), 32'd1);
    @(posedge clk); #1;
    if (keep_req) begin req_op = SEQ_ADD; req_a = 32'd1; req_b = 32'd1; end
    else req_valid = 1'b0;
    ctl = exec_ctl(op);
    if (ctl >= 0) begin
      check({nm, "_exec_ctl"}, 32'(alu_ctl), 32'(ctl));
      check({nm, "_exec_a"}, alu_a, (ctl == 2 && exp_e) ? 32'd0 : a);
      check({nm, "_exec_b"}, alu_b, (ctl == 2 && exp_e) ? 32'd0 : b);
    end
    lat = 1;
    while (!rsp_valid && lat < 60) begin
      if (keep_req) check({nm, "_busy_ready"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1; lat++;
    end
    req_valid = 1'b0;
    check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    check({nm, "_data"}, rsp_data, exp_d);
    check({nm, "_err"}, 32'(rsp_err), 32'(exp_e));
    check({nm, "_done_alu"}, {alu_ctl, alu_a[13:0], alu_b[13:0]}, {4'd2, 28'd0});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({nm, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({nm, "_hold_data"}, rsp_data, exp_d);
      check({nm, "_hold_err"}, 32'(rsp_err), 32'(exp_e));
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    check({nm, "_taken_valid"}, 32'(rsp_valid), 32'd0);
    check({nm, "_taken_ready"}, 32'(req_ready), 32'd1);
    if (keep_req) begin
      repeat (3) begin
        @(posedge clk); #1;
        check({nm, "_not_queued"}, {31'd0, rsp_valid}, 32'd0);
        check({nm, "_idle_ready"}, 32'(req_ready), 32'd1);
      end
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_a = 32'd0; req_b = 32'd0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_alu", {alu_ctl, alu_a[13:0], alu_b[13:0]}, {4'd2, 28'd0});
    check("rst_alu_ab", alu_a | alu_b, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed cases
    do_op(SEQ_ADD,  32'd7, 32'd5, 0, 1'b0);
    do_op(SEQ_BEQ,  32'h55, 32'h55, 0, 1'b0);
    do_op(SEQ_BNE,  32'h55, 32'h55, 0, 1'b0);
    do_op(SEQ_BLTU, 32'd1, 32'd2, 0, 1'b0);
    do_op(SEQ_SLTU, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    do_op(SEQ_SLL,  32'd1, 32'd31, 0, 1'b0);
    do_op(SEQ_SLL,  32'hDEAD_BEEF, 32'hFFFF_FFE0, 0, 1'b0);
    do_op(SEQ_MUL,  32'hFFFF_FFFF, 32'd3, 0, 1'b1);
    do_op(SEQ_SUB,  32'd3, 32'd10, 5, 1'b0);
    do_op(4'hF,     32'h1234_5678, 32'h9ABC_DEF0, 1, 1'b0);

    // Reset in the middle of a MUL
    @(negedge clk);
    req_valid = 1'b1; req_op = SEQ_MUL; req_a = 32'h0001_0001; req_b = 32'h0000_0100;
    @(negedge clk); req_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_data", rsp_data, 32'd0);
    check("midrst_rsp_err", 32'(rsp_err), 32'd0);
    check("midrst_alu_ctl", 32'(alu_ctl), 32'd2);
    check("midrst_alu_ab", alu_a | alu_b, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    do_op(SEQ_ADD, 32'h8000_0000, 32'h8000_0001, 0, 1'b0);

    // Random requests, including illegal codes
    for (int n = 0; n < 24; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      do_op(rop, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
